mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch port and its data (load/store) port.
- Sits between rv32i core and the memory macro:
  - fetch side connects to the core's instruction address/instruction/valid signals;
  - data side connects to the core's data memory address/write-data/read-data/width/rw signals.
- Sequences one memory transaction at a time, with back-to-back issue. Data has priority because it is the older instruction in the pipeline.
- Returns responses to the owning requester and supports discarding an in-flight fetch on a pipeline flush.

Parameters:
- size, 32, address/data width.
- STARVE_LIMIT, 4, consecutive denied-fetch cycles before fetch is forced (only used with ARB_FAIR_EN).

Ports:
- clk  input  1  clock; everything on the rising edge.
- reset  input  1  synchronous, active-high reset.
- i_req  input  1  fetch request; held stable with i_addr until i_gnt.
- i_addr  input  size  fetch address.
- i_flush  input  1  misprediction flush; discard the in-flight fetch response.
- i_gnt  output  1  fetch accepted this cycle.
- i_valid  output  1  one-cycle pulse; i_rdata is valid.
- i_rdata  output  size  fetched instruction (combinational from mem_rdata).
- d_req  input  1  data request; held stable with d_* until d_gnt.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  size  data address.
- d_wdata  input  size  store data.
- d_width  input  3  funct3 width/sign code, passed through unchanged.
- d_gnt  output  1  data accepted this cycle.
- d_done  output  1  one-cycle pulse; load data captured or store acknowledged.
- d_rdata  output  size  registered load data, held until the next load completes.
- mem_req  output  1  request to memory.
- mem_we  output  1  write enable.
- mem_addr  output  size  address.
- mem_wdata  output  size  write data.
- mem_width  output  3  width code.
- mem_gnt  input  1  memory accepts mem_req this cycle.
- mem_rvalid  input  1  response for the oldest accepted request (loads and stores).
- mem_rdata  input  size  read data, valid with mem_rvalid.
- protocol_err  output  1  sticky: mem_rvalid arrived with nothing outstanding.

Behaviour:
- States: IDLE, I_WAIT (fetch outstanding), D_WAIT (data outstanding). At most one transaction is outstanding.
- Issue window: the state is IDLE, or the state is *_WAIT and mem_rvalid=1 this cycle (back-to-back issue).
- Selection inside the issue window:
  - d_req=1: choose data.
  - else i_req=1: choose fetch.
  - else mem_req=0.
- mem_* outputs are a combinational mux of the selected requester. Outside the issue window, mem_req=0.
- Grants:
  - i_gnt/d_gnt = selected & mem_req & mem_gnt.
  - On grant, the next state is I_WAIT or D_WAIT.
  - On mem_rvalid with no new grant, the next state is IDLE.
- Fetch responses:
  - In I_WAIT, mem_rvalid drives i_valid=1 for one cycle.
  - i_valid is suppressed if the flag flush_pend is set, or if i_flush=1 in the response cycle.
- flush_pend:
  - Set when i_flush=1 while in I_WAIT, or in the same cycle as a fetch grant.
  - Cleared when that response retires.
  - A fetch granted in the response cycle is not affected by that cycle's i_flush unless i_flush is also sampled in its own grant cycle.
- i_flush in IDLE or D_WAIT has no effect.
- Data responses:
  - In D_WAIT, mem_rvalid pulses d_done for one cycle.
  - For a load (latched d_we=0), mem_rdata is registered into d_rdata.
  - For a store, d_rdata is unchanged.
- Response latency: the arbiter adds zero cycles. With a 1-cycle memory, a request granted at cycle N responds at N+1, and the next request may be granted at N+1.
- mem_rvalid in IDLE sets protocol_err (sticky until reset) and is otherwise ignored.
- Simultaneous i_req and d_req: data wins. Fetch waits with i_gnt=0, and its address is held by the requester.
- mem_gnt=0: no state change; the request stays asserted the next cycle (same selection rule re-evaluated).
- Reset values (while reset=1 and the first cycle after):
  - state=IDLE; i_valid, d_done, i_gnt, d_gnt, mem_req, protocol_err, flush_pend = 0; d_rdata = 0.
- Reset mid-transaction abandons the outstanding transaction. Memory shares the same reset, so no stale rvalid is expected.

Optional Feature:
- Macro: ARB_FAIR_EN.
- When defined:
  - A starvation counter increments each cycle that i_req=1 inside the issue window without i_gnt.
  - The counter clears on i_gnt or when i_req=0.
  - When the counter equals STARVE_LIMIT, fetch is selected over data for that issue window; data waits.
- When undefined: strict data priority; no counter logic is present.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, mem_gnt=1, mem_rdata=0x00500093 at N+1 -> i_gnt@N, i_valid@N+1 with i_rdata=0x00500093, state returns to IDLE.
- Collision: i_req and d_req both 1 (d_we=0, d_addr=0x2000), memory returns 0xDEADBEEF -> d_gnt@N, d_done@N+1 with d_rdata=0xDEADBEEF held; i_gnt@N+1, i_valid@N+2.
- Store back-to-back: d_req with d_we=1, d_addr=0x2004, d_wdata=0x12345678, d_width=3'b010, then fetch -> mem_we=1 with those values, d_done@N+1 with d_rdata unchanged, fetch granted @N+1.
- Flush: fetch granted @N, i_flush=1 @N, rvalid @N+1 -> no i_valid. Repeat with flush @N+1 -> no i_valid. Fetch granted @N+1 without flush -> i_valid @N+2.
- Backpressure/errors: mem_gnt=0 for 3 cycles -> mem_req stays 1 with stable address and no grants. mem_rvalid pulse in IDLE -> protocol_err=1 until reset.
- ARB_FAIR_EN, STARVE_LIMIT=4, d_req and i_req both held 1 continuously -> 4 data grants, then 1 fetch grant, repeating. Synchronous reset mid-pattern -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of mem_port_arbiter.
interface mem_port_arbiter_if #(parameter int size = 32);
  logic i_req, i_flush, i_gnt, i_valid;
  logic [size-1:0] i_addr, i_rdata;
  logic d_req, d_we, d_gnt, d_done;
  logic [size-1:0] d_addr, d_wdata, d_rdata;
  logic [2:0] d_width, mem_width;
  logic mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [size-1:0] mem_addr, mem_wdata, mem_rdata;
  logic protocol_err;
  modport slave (
    input i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, d_width, mem_gnt, mem_rvalid, mem_rdata,
    output i_gnt, i_valid, i_rdata, d_gnt, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_width, protocol_err
  );
  modport master (
    output i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, d_width, mem_gnt, mem_rvalid, mem_rdata,
    input i_gnt, i_valid, i_rdata, d_gnt, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_width, protocol_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data ports, data first.
// Optional ARB_FAIR_EN forces a fetch once it has been denied STARVE_LIMIT issue windows.
module mem_port_arbiter #(
  parameter int size = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT} state_t;
  state_t state;
  logic flush_pend, d_load, perr, win, sel_d, sel_i, force_i;
  logic [size-1:0] d_rdata_q;
`ifdef ARB_FAIR_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve;
  assign force_i = bus.i_req && (starve == CW'(STARVE_LIMIT));
  always_ff @(posedge clk)
    if (reset || !bus.i_req || bus.i_gnt) starve <= '0;
    else if (win && starve != CW'(STARVE_LIMIT)) starve <= starve + 1'b1;
`else
  assign force_i = STARVE_LIMIT < 0;
`endif
  // A response cycle doubles as the next issue slot, so memory never idles between requests.
  assign win = !reset && (state == IDLE || bus.mem_rvalid);
  assign sel_d = bus.d_req && !force_i;
  assign sel_i = bus.i_req && !sel_d;
  assign bus.mem_req = win && (sel_d || sel_i);
  assign bus.mem_we = sel_d && bus.d_we;
  assign bus.mem_addr = sel_d ? bus.d_addr : bus.i_addr;
  assign bus.mem_wdata = sel_d ? bus.d_wdata : '0;
  assign bus.mem_width = sel_d ? bus.d_width : 3'b010;
  assign bus.i_gnt = bus.mem_req && sel_i && bus.mem_gnt;
  assign bus.d_gnt = bus.mem_req && sel_d && bus.mem_gnt;
  assign bus.i_valid = !reset && state == I_WAIT && bus.mem_rvalid && !flush_pend && !bus.i_flush;
  assign bus.d_done = !reset && state == D_WAIT && bus.mem_rvalid;
  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = d_rdata_q;
  assign bus.protocol_err = perr;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      flush_pend <= 1'b0;
      d_load <= 1'b0;
      perr <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      state <= bus.i_gnt ? I_WAIT : bus.d_gnt ? D_WAIT : bus.mem_rvalid ? IDLE : state;
      flush_pend <= bus.i_gnt ? bus.i_flush : state == I_WAIT && !bus.mem_rvalid && (flush_pend || bus.i_flush);
      if (bus.d_gnt) d_load <= !bus.d_we;
      if (bus.d_done && d_load) d_rdata_q <= bus.mem_rdata;
      if (state == IDLE && bus.mem_rvalid) perr <= 1'b1;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table, directed and randomized checks of mem_port_arbiter against a transaction model.
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.size(32)) bus();
  mem_port_arbiter #(.size(32), .STARVE_LIMIT(4)) dut (.clk(clk), .reset(rst), .bus(bus));

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] st();
    return {27'b0, bus.mem_req, bus.i_gnt, bus.d_gnt, bus.i_valid, bus.d_done};
  endfunction
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0F0F5A5A;
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask

  // memory: accepts on mem_req&mem_gnt, responds after a fixed or random latency
  int gnt_mode = 0, lat = 1, cnt = 0;
  bit lat_rand = 0, inject = 0;
  logic [31:0] r_addr;
  logic [31:0] ram [logic [31:0]];
  function automatic logic [31:0] rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_word(a);
  endfunction
  initial begin
    ram[32'h100] = 32'h00500093;
    ram[32'h104] = 32'h00100113;
    ram[32'h110] = 32'h00310213;
    ram[32'h200] = 32'h00000013;
    ram[32'h2000] = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      if (rst) cnt = 0;
      else if (bus.mem_req && bus.mem_gnt) begin
        cnt = lat_rand ? int'($urandom_range(1, 3)) : lat;
        r_addr = bus.mem_addr;
        if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
      end
      @(posedge clk);
      #1;
      bus.mem_rvalid = inject;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata = rd(r_addr);
        end
      end
      bus.mem_gnt = gnt_mode == 0 ? 1'b1 : gnt_mode == 1 ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // transaction-level reference: queue of accepted requests, golden memory image
  typedef struct {bit fetch; bit fl; bit load; logic [31:0] val;} txn_t;
  txn_t q[$];
  txn_t t;
  logic [31:0] gold [logic [31:0]];
  logic [31:0] drd_exp;
  bit rnd_on = 0, rv, win, eg_d, eg_i, ev, ed, ig_last, dg_last;
  function automatic logic [31:0] gd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_word(a);
  endfunction
  always @(negedge clk)
    if (!rnd_on) begin
      q.delete();
      drd_exp = '0;
      ig_last = 0;
      dg_last = 0;
    end else begin
      rv = bus.mem_rvalid;
      win = q.size() == 0 || rv;
      eg_d = win && bus.d_req && bus.mem_gnt;
      eg_i = win && bus.i_req && !bus.d_req && bus.mem_gnt;
      ev = 0;
      ed = 0;
      chk("rnd_drdata", bus.d_rdata, drd_exp);
      chk("rnd_perr", 32'(bus.protocol_err), 0);
      if (rv && q.size() > 0) begin
        t = q.pop_front();
        if (t.fetch) begin
          ev = !t.fl && !bus.i_flush;
          if (ev) chk("rnd_irdata", bus.i_rdata, t.val);
        end else begin
          ed = 1;
          if (t.load) drd_exp = t.val;
        end
      end else if (q.size() > 0 && bus.i_flush) q[0].fl = 1;
      chk("rnd_ivalid", 32'(bus.i_valid), 32'(ev));
      chk("rnd_ddone", 32'(bus.d_done), 32'(ed));
      chk("rnd_ignt", 32'(bus.i_gnt), 32'(eg_i));
      chk("rnd_dgnt", 32'(bus.d_gnt), 32'(eg_d));
      if (eg_d) begin
        q.push_back('{fetch: 1'b0, fl: 1'b0, load: !bus.d_we, val: gd(bus.d_addr)});
        if (bus.d_we) gold[bus.d_addr] = bus.d_wdata;
      end
      if (eg_i) q.push_back('{fetch: 1'b1, fl: bus.i_flush, load: 1'b0, val: gd(bus.i_addr)});
      ig_last = bus.i_gnt;
      dg_last = bus.d_gnt;
    end

  typedef struct {bit i; bit d; bit we; bit g; logic [4:0] exp;} vec_t;
  vec_t vt[8];

  initial begin
    // {i_req, d_req, d_we, mem_gnt} from IDLE -> {mem_req, i_gnt, d_gnt, mem_we, addr_is_data}
    vt[0] = '{0, 0, 0, 1, 5'b00000};
    vt[1] = '{1, 0, 0, 1, 5'b11000};
    vt[2] = '{0, 1, 0, 1, 5'b10101};
    vt[3] = '{1, 1, 1, 1, 5'b10111};
    vt[4] = '{1, 0, 1, 1, 5'b11000};
    vt[5] = '{1, 0, 0, 0, 5'b10000};
    vt[6] = '{0, 1, 1, 0, 5'b10011};
    vt[7] = '{1, 1, 0, 0, 5'b10001};
    bus.i_flush = 0; bus.d_we = 0; bus.i_addr = 32'h100; bus.d_addr = 32'h2000;
    bus.d_wdata = '0; bus.d_width = '0;
    bus.i_req = 1; bus.d_req = 1;
    cyc(); cyc(); settle();
    chk("rst_outs", st(), 0);
    chk("rst_perr", 32'(bus.protocol_err), 0);
    chk("rst_drdata", bus.d_rdata, 0);
    rst = 0; bus.i_req = 0; bus.d_req = 0;
    cyc(); settle();
    chk("rst_first", st(), 0);

    rst = 1;
    for (int k = 0; k < 8; k++) begin
      cyc(); rst = 0; settle();
      gnt_mode = vt[k].g ? 0 : 1;
      cyc();
      bus.i_req = vt[k].i; bus.d_req = vt[k].d; bus.d_we = vt[k].we;
      settle();
      chk($sformatf("tbl%0d", k), {27'b0, bus.mem_req, bus.i_gnt, bus.d_gnt, bus.mem_we, bus.mem_addr == 32'h2000}, 32'(vt[k].exp));
      rst = 1; bus.i_req = 0; bus.d_req = 0; bus.d_we = 0;
    end
    gnt_mode = 0;
    cyc(); rst = 0; settle();

    cyc(); bus.i_req = 1; bus.i_addr = 32'h100; settle();
    chk("f_issue", st(), 32'b11000);
    chk("f_addr", bus.mem_addr, 32'h100);
    cyc(); bus.i_req = 0; settle();
    chk("f_resp", st(), 32'b00010);
    chk("f_rdata", bus.i_rdata, 32'h00500093);
    cyc(); settle();
    chk("f_idle", st(), 0);

    cyc(); bus.i_req = 1; bus.i_addr = 32'h104; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h2000; settle();
    chk("col_issue", st(), 32'b10100);
    chk("col_addr", bus.mem_addr, 32'h2000);
    cyc(); bus.d_req = 0; settle();
    chk("col_b2b", st(), 32'b11001);
    chk("col_faddr", bus.mem_addr, 32'h104);
    cyc(); bus.i_req = 0; settle();
    chk("col_fresp", st(), 32'b00010);
    chk("col_irdata", bus.i_rdata, 32'h00100113);
    chk("col_drdata", bus.d_rdata, 32'hDEADBEEF);
    cyc(); settle();
    chk("col_hold", bus.d_rdata, 32'hDEADBEEF);

    cyc();
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2004; bus.d_wdata = 32'h12345678; bus.d_width = 3'b010;
    bus.i_req = 1; bus.i_addr = 32'h200;
    settle();
    chk("st_issue", st(), 32'b10100);
    chk("st_we", 32'(bus.mem_we), 1);
    chk("st_addr", bus.mem_addr, 32'h2004);
    chk("st_wdata", bus.mem_wdata, 32'h12345678);
    chk("st_width", 32'(bus.mem_width), 2);
    cyc(); bus.d_req = 0; bus.d_we = 0; settle();
    chk("st_b2b", st(), 32'b11001);
    cyc(); bus.i_req = 0; settle();
    chk("st_fresp", st(), 32'b00010);
    chk("st_drdata", bus.d_rdata, 32'hDEADBEEF);

    cyc(); bus.i_req = 1; bus.i_addr = 32'h10C; bus.i_flush = 1; settle();
    chk("fl_issue", st(), 32'b11000);
    cyc(); bus.i_flush = 0; bus.i_addr = 32'h110; settle();
    chk("fl_drop_regrant", st(), 32'b11000);
    cyc(); bus.i_req = 0; settle();
    chk("fl_next_valid", st(), 32'b00010);
    chk("fl_next_rdata", bus.i_rdata, 32'h00310213);
    cyc(); bus.i_req = 1; bus.i_addr = 32'h100; settle();
    chk("fl2_issue", st(), 32'b11000);
    cyc(); bus.i_req = 0; bus.i_flush = 1; settle();
    chk("fl2_drop", st(), 0);
    cyc(); bus.i_flush = 0; settle();
    chk("fl2_idle", st(), 0);

    lat = 2;
    cyc(); bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h2000; bus.i_req = 1; bus.i_addr = 32'h100; bus.i_flush = 1; settle();
    chk("nf_issue", st(), 32'b10100);
    cyc(); bus.d_req = 0; settle();
    chk("nf_dwait", st(), 0);
    cyc(); bus.i_flush = 0; settle();
    chk("nf_b2b", st(), 32'b11001);
    cyc(); bus.i_req = 0; settle();
    chk("nf_iwait", st(), 0);
    cyc(); settle();
    chk("nf_valid", st(), 32'b00010);
    chk("nf_rdata", bus.i_rdata, 32'h00500093);
    lat = 1;

    gnt_mode = 1;
    for (int k = 0; k < 3; k++) begin
      cyc(); bus.i_req = 1; bus.i_addr = 32'h200; settle();
      chk("bp_hold", st(), 32'b10000);
      chk("bp_addr", bus.mem_addr, 32'h200);
    end
    gnt_mode = 0;
    cyc(); settle();
    chk("bp_release", st(), 32'b11000);
    cyc(); bus.i_req = 0; settle();
    chk("bp_resp", st(), 32'b00010);
    chk("bp_rdata", bus.i_rdata, 32'h00000013);

    inject = 1;
    cyc(); settle();
    chk("perr_ignored", st(), 0);
    inject = 0;
    cyc(); settle();
    chk("perr_set", 32'(bus.protocol_err), 1);
    cyc(); cyc(); settle();
    chk("perr_sticky", 32'(bus.protocol_err), 1);
    cyc(); bus.i_req = 1; bus.i_addr = 32'h100; settle();
    chk("rmid_issue", st(), 32'b11000);
    rst = 1;
    cyc(); settle();
    chk("rmid_outs", st(), 0);
    cyc(); settle();
    chk("rmid_perr", 32'(bus.protocol_err), 0);
    rst = 0; bus.i_req = 0;
    cyc(); settle();
    chk("rmid_idle", st(), 0);

    for (int c = 0; c < 10; c++) begin
      cyc(); bus.i_req = 1; bus.i_addr = 32'h100; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h2000; settle();
`ifdef ARB_FAIR_EN
      chk("prio_seq", {30'b0, bus.i_gnt, bus.d_gnt}, c % 5 == 4 ? 32'b10 : 32'b01);
`else
      chk("prio_seq", {30'b0, bus.i_gnt, bus.d_gnt}, 32'b01);
`endif
    end
    rst = 1;
    cyc(); settle();
    chk("prio_rst", st(), 0);
    bus.i_req = 0; bus.d_req = 0;

`ifndef ARB_FAIR_EN
    cyc(); rst = 0; settle();
    gnt_mode = 2; lat_rand = 1; rnd_on = 1;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (!bus.i_req || ig_last) begin
        bus.i_req = $urandom_range(0, 1) != 0;
        bus.i_addr = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
      end
      if (!bus.d_req || dg_last) begin
        bus.d_req = $urandom_range(0, 1) != 0;
        bus.d_we = $urandom_range(0, 1) != 0;
        bus.d_addr = 32'h3000 + (32'($urandom_range(0, 15)) << 2);
        bus.d_wdata = $urandom;
        bus.d_width = 3'($urandom_range(0, 7));
      end
      bus.i_flush = $urandom_range(0, 7) == 0;
    end
    rnd_on = 0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
